// File: rtl/time_keeper_bcd.sv
// BCD wall clock advanced by rising edges of the 1 Hz sec input, with a validated load port
// and minute/hour adjust pulses. H12 selects 12-hour display with a PM flag.
module time_keeper_bcd #(
    parameter bit H12 = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec,
    input  logic       load,
    input  logic [1:0] ld_hr_t,
    input  logic [3:0] ld_hr_o,
    input  logic [2:0] ld_min_t,
    input  logic [3:0] ld_min_o,
    input  logic       ld_pm,
    input  logic       inc_min,
    input  logic       inc_hr,
    output logic [1:0] hr_t,
    output logic [3:0] hr_o,
    output logic [2:0] min_t,
    output logic [3:0] min_o,
    output logic [2:0] sec_t,
    output logic [3:0] sec_o,
    output logic       pm,
    output logic       tick,
    output logic       load_err
);

    localparam logic [1:0] HrTRst = H12 ? 2'd1 : 2'd0;
    localparam logic [3:0] HrORst = H12 ? 4'd2 : 4'd0;

    logic [1:0] hr_t_q, hr_t_d;
    logic [3:0] hr_o_q, hr_o_d;
    logic [2:0] min_t_q, min_t_d;
    logic [3:0] min_o_q, min_o_d;
    logic [2:0] sec_t_q, sec_t_d;
    logic [3:0] sec_o_q, sec_o_d;
    logic       pm_q, pm_d;
    logic       tick_q, tick_d;
    logic       load_err_q, load_err_d;
    logic       pend_q, pend_d;
    logic       sec_dly_q;
    logic       rise;
    logic       min_ok, hr_ok, load_ok;

    // Minutes +1 with 59 -> 00 wrap; returns {tens, ones}.
    function automatic logic [6:0] min_inc(input logic [2:0] t, input logic [3:0] o);
        logic [2:0] nt;
        logic [3:0] no;
        nt = t;
        no = o;
        if (o != 4'd9) begin
            no = o + 4'd1;
        end else begin
            no = 4'd0;
            nt = (t == 3'd5) ? 3'd0 : t + 3'd1;
        end
        return {nt, no};
    endfunction

    // Hour +1 for the selected mode; returns {pm, tens, ones}.
    function automatic logic [6:0] hr_inc(input logic p, input logic [1:0] t, input logic [3:0] o);
        logic       np;
        logic [1:0] nt;
        logic [3:0] no;
        np = p;
        nt = t;
        no = o;
        if (!H12 && t == 2'd2 && o == 4'd3) begin
            nt = 2'd0;
            no = 4'd0;
        end else if (H12 && t == 2'd1 && o == 4'd2) begin
            nt = 2'd0;
            no = 4'd1;
        end else if (H12 && t == 2'd1 && o == 4'd1) begin
            no = 4'd2;
            np = ~p;
        end else if (o == 4'd9) begin
            nt = t + 2'd1;
            no = 4'd0;
        end else begin
            no = o + 4'd1;
        end
        return {np, nt, no};
    endfunction

    always_comb begin
        rise   = sec & ~sec_dly_q;
        min_ok = (ld_min_t <= 3'd5) && (ld_min_o <= 4'd9);
        if (H12) begin
            hr_ok = ((ld_hr_t == 2'd0) && (ld_hr_o >= 4'd1) && (ld_hr_o <= 4'd9)) ||
                    ((ld_hr_t == 2'd1) && (ld_hr_o <= 4'd2));
        end else begin
            hr_ok = (ld_hr_o <= 4'd9) &&
                    ((ld_hr_t < 2'd2) || ((ld_hr_t == 2'd2) && (ld_hr_o <= 4'd3)));
        end
        load_ok = min_ok && hr_ok;
    end

    always_comb begin
        hr_t_d     = hr_t_q;
        hr_o_d     = hr_o_q;
        min_t_d    = min_t_q;
        min_o_d    = min_o_q;
        sec_t_d    = sec_t_q;
        sec_o_d    = sec_o_q;
        pm_d       = pm_q;
        pend_d     = pend_q;
        tick_d     = 1'b0;
        load_err_d = 1'b0;

        if (load) begin
            // A coincident rise or pending tick is dropped whether or not the load is accepted.
            pend_d = 1'b0;
            if (load_ok) begin
                hr_t_d  = ld_hr_t;
                hr_o_d  = ld_hr_o;
                min_t_d = ld_min_t;
                min_o_d = ld_min_o;
                pm_d    = H12 ? ld_pm : 1'b0;
                sec_t_d = 3'd0;
                sec_o_d = 4'd0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (inc_min || inc_hr) begin
            if (inc_min) begin
                {min_t_d, min_o_d} = min_inc(min_t_q, min_o_q);
            end
            if (inc_hr) begin
                {pm_d, hr_t_d, hr_o_d} = hr_inc(pm_q, hr_t_q, hr_o_q);
            end
            if (rise) begin
                pend_d = 1'b1;
            end
        end else if (rise || pend_q) begin
            tick_d = 1'b1;
            pend_d = 1'b0;
            if (sec_o_q != 4'd9) begin
                sec_o_d = sec_o_q + 4'd1;
            end else begin
                sec_o_d = 4'd0;
                if (sec_t_q != 3'd5) begin
                    sec_t_d = sec_t_q + 3'd1;
                end else begin
                    sec_t_d = 3'd0;
                    {min_t_d, min_o_d} = min_inc(min_t_q, min_o_q);
                    if (min_t_q == 3'd5 && min_o_q == 4'd9) begin
                        {pm_d, hr_t_d, hr_o_d} = hr_inc(pm_q, hr_t_q, hr_o_q);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hr_t_q     <= HrTRst;
            hr_o_q     <= HrORst;
            min_t_q    <= 3'd0;
            min_o_q    <= 4'd0;
            sec_t_q    <= 3'd0;
            sec_o_q    <= 4'd0;
            pm_q       <= 1'b0;
            tick_q     <= 1'b0;
            load_err_q <= 1'b0;
            pend_q     <= 1'b0;
            // Reset high so the divider's reset-high sec does not look like an edge.
            sec_dly_q  <= 1'b1;
        end else begin
            hr_t_q     <= hr_t_d;
            hr_o_q     <= hr_o_d;
            min_t_q    <= min_t_d;
            min_o_q    <= min_o_d;
            sec_t_q    <= sec_t_d;
            sec_o_q    <= sec_o_d;
            pm_q       <= pm_d;
            tick_q     <= tick_d;
            load_err_q <= load_err_d;
            pend_q     <= pend_d;
            sec_dly_q  <= sec;
        end
    end

    assign hr_t     = hr_t_q;
    assign hr_o     = hr_o_q;
    assign min_t    = min_t_q;
    assign min_o    = min_o_q;
    assign sec_t    = sec_t_q;
    assign sec_o    = sec_o_q;
    assign pm       = pm_q;
    assign tick     = tick_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_time_keeper_bcd.sv
// Bench for time_keeper_bcd: a 24-hour and a 12-hour instance share stimulus and are checked
// every cycle against a seconds-of-day model, plus literal spot checks.
module tb_time_keeper_bcd;

    logic       clk = 1'b0;
    logic       rst, sec, load, ld_pm, inc_min, inc_hr;
    logic [1:0] ld_hr_t;
    logic [3:0] ld_hr_o;
    logic [2:0] ld_min_t;
    logic [3:0] ld_min_o;

    logic [1:0] hr_t_w  [2];
    logic [3:0] hr_o_w  [2];
    logic [2:0] min_t_w [2];
    logic [3:0] min_o_w [2];
    logic [2:0] sec_t_w [2];
    logic [3:0] sec_o_w [2];
    logic       pm_w    [2];
    logic       tick_w  [2];
    logic       err_w   [2];

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    always #10 clk = ~clk;

    time_keeper_bcd #(.H12(1'b0)) u_dut24 (
        .clk(clk), .rst(rst), .sec(sec), .load(load),
        .ld_hr_t(ld_hr_t), .ld_hr_o(ld_hr_o), .ld_min_t(ld_min_t), .ld_min_o(ld_min_o),
        .ld_pm(ld_pm), .inc_min(inc_min), .inc_hr(inc_hr),
        .hr_t(hr_t_w[0]), .hr_o(hr_o_w[0]), .min_t(min_t_w[0]), .min_o(min_o_w[0]),
        .sec_t(sec_t_w[0]), .sec_o(sec_o_w[0]), .pm(pm_w[0]), .tick(tick_w[0]),
        .load_err(err_w[0])
    );

    time_keeper_bcd #(.H12(1'b1)) u_dut12 (
        .clk(clk), .rst(rst), .sec(sec), .load(load),
        .ld_hr_t(ld_hr_t), .ld_hr_o(ld_hr_o), .ld_min_t(ld_min_t), .ld_min_o(ld_min_o),
        .ld_pm(ld_pm), .inc_min(inc_min), .inc_hr(inc_hr),
        .hr_t(hr_t_w[1]), .hr_o(hr_o_w[1]), .min_t(min_t_w[1]), .min_o(min_o_w[1]),
        .sec_t(sec_t_w[1]), .sec_o(sec_o_w[1]), .pm(pm_w[1]), .tick(tick_w[1]),
        .load_err(err_w[1])
    );

    // Model state: time as seconds since midnight (12 AM == 0 in 12-hour mode).
    typedef struct packed {
        logic [16:0] t;
        logic        pend;
        logic        tick;
        logic        err;
    } mst_t;

    mst_t ms [2];
    logic msecd;

    function automatic mst_t step(input int mode, input mst_t s, input logic rise);
        mst_t n;
        int   t, hv, mv, h24, m;
        bit   ok;
        n      = s;
        n.tick = 1'b0;
        n.err  = 1'b0;
        t      = int'(s.t);
        if (load) begin
            n.pend = 1'b0;
            hv = 10 * int'(ld_hr_t) + int'(ld_hr_o);
            mv = 10 * int'(ld_min_t) + int'(ld_min_o);
            ok = (ld_hr_o <= 4'd9) && (ld_min_o <= 4'd9) && (mv <= 59);
            ok = ok && ((mode == 1) ? (hv >= 1 && hv <= 12) : (hv <= 23));
            if (ok) begin
                h24 = (mode == 1) ? ((hv % 12) + (ld_pm ? 12 : 0)) : hv;
                t   = h24 * 3600 + mv * 60;
            end else begin
                n.err = 1'b1;
            end
        end else if (inc_min || inc_hr) begin
            if (inc_min) begin
                m = (t / 60) % 60;
                t = t + (((m + 1) % 60) - m) * 60;
            end
            if (inc_hr) t = (t + 3600) % 86400;
            if (rise) n.pend = 1'b1;
        end else if (rise || s.pend) begin
            t      = (t + 1) % 86400;
            n.tick = 1'b1;
            n.pend = 1'b0;
        end
        n.t = 17'(t);
        return n;
    endfunction

    function automatic logic [22:0] expect_vec(input int mode, input mst_t s);
        int t, h24, h, mi, se;
        bit p;
        t   = int'(s.t);
        h24 = t / 3600;
        mi  = (t / 60) % 60;
        se  = t % 60;
        if (mode == 1) begin
            p = (h24 >= 12);
            h = h24 % 12;
            if (h == 0) h = 12;
        end else begin
            p = 1'b0;
            h = h24;
        end
        return {2'(h / 10), 4'(h % 10), 3'(mi / 10), 4'(mi % 10), 3'(se / 10), 4'(se % 10),
                p, s.tick, s.err};
    endfunction

    function automatic logic [22:0] got_vec(input int m);
        return {hr_t_w[m], hr_o_w[m], min_t_w[m], min_o_w[m], sec_t_w[m], sec_o_w[m],
                pm_w[m], tick_w[m], err_w[m]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ms[0] <= '0;
            ms[1] <= '0;
            msecd <= 1'b1;
        end else begin
            ms[0] <= step(0, ms[0], sec & ~msecd);
            ms[1] <= step(1, ms[1], sec & ~msecd);
            msecd <= sec;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (got_vec(m) !== expect_vec(m, ms[m])) begin
                    miscompares++;
                    $display("FAIL model_cmp dut%0d t=%0t got=%h exp=%h", m, $time,
                             got_vec(m), expect_vec(m, ms[m]));
                end
            end
        end
    end

    task automatic chk_time(input string name, input int m, input logic [19:0] exp);
        vectors++;
        if (got_vec(m)[22:3] !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d got=%h exp=%h", name, m, got_vec(m)[22:3], exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [1:0] ht, input logic [3:0] ho, input logic [2:0] mt,
                           input logic [3:0] mo, input logic p);
        ld_hr_t  = ht;
        ld_hr_o  = ho;
        ld_min_t = mt;
        ld_min_o = mo;
        ld_pm    = p;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic rises(input int n);
        repeat (n) begin
            sec = 1'b0;
            @(negedge clk);
            sec = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; sec = 1'b1; load = 1'b0; ld_pm = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
        ld_hr_t = '0; ld_hr_o = '0; ld_min_t = '0; ld_min_o = '0;
        idle(3);
        chk_en = 1'b1;
        chk_time("reset24", 0, {2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd0});
        chk_time("reset12", 1, {2'd1, 4'd2, 3'd0, 4'd0, 3'd0, 4'd0});
        rst = 1'b0;

        // sec held high out of reset must not advance
        idle(100);
        chk_time("hold_high", 0, {2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd0});
        rises(1);
        chk_time("first_rise", 0, {2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd1});
        chk_bit("first_tick", tick_w[0], 1'b1);
        idle(1);
        chk_bit("tick_drop", tick_w[0], 1'b0);

        // 24h rollover; 23:59 is illegal for the 12h instance
        do_load(2'd2, 4'd3, 3'd5, 4'd9, 1'b0);
        chk_bit("err12_2359", err_w[1], 1'b1);
        rises(59);
        chk_time("t235959", 0, {2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9});
        rises(1);
        chk_time("roll24", 0, {2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd0});

        // 12h: 11:59 AM -> 12:00 PM, then 12:59 PM -> 01:00 PM
        do_load(2'd1, 4'd1, 3'd5, 4'd9, 1'b0);
        rises(60);
        chk_time("roll12_noon", 1, {2'd1, 4'd2, 3'd0, 4'd0, 3'd0, 4'd0});
        chk_bit("pm_noon", pm_w[1], 1'b1);
        do_load(2'd1, 4'd2, 3'd5, 4'd9, 1'b1);
        rises(60);
        chk_time("roll12_one", 1, {2'd0, 4'd1, 3'd0, 4'd0, 3'd0, 4'd0});
        chk_bit("pm_one", pm_w[1], 1'b1);

        // invalid loads
        do_load(2'd2, 4'd4, 3'd0, 4'd0, 1'b0);
        chk_bit("err24_h24", err_w[0], 1'b1);
        do_load(2'd0, 4'd1, 3'd0, 4'hA, 1'b0);
        chk_bit("err24_minA", err_w[0], 1'b1);
        do_load(2'd0, 4'd0, 3'd0, 4'd0, 1'b0);
        chk_bit("err12_h00", err_w[1], 1'b1);
        chk_bit("ok24_h00", err_w[0], 1'b0);
        chk_time("keep12", 1, {2'd0, 4'd1, 3'd0, 4'd0, 3'd0, 4'd0});

        // rise coincident with inc_min defers the tick by one cycle
        do_load(2'd1, 4'd0, 3'd2, 4'd0, 1'b0);
        rises(30);
        sec = 1'b0;
        @(negedge clk);
        sec = 1'b1; inc_min = 1'b1;
        @(negedge clk);
        inc_min = 1'b0;
        chk_time("defer_inc", 0, {2'd1, 4'd0, 3'd2, 4'd1, 3'd3, 4'd0});
        chk_bit("defer_notick", tick_w[0], 1'b0);
        @(negedge clk);
        chk_time("defer_apply", 0, {2'd1, 4'd0, 3'd2, 4'd1, 3'd3, 4'd1});
        chk_bit("defer_tick", tick_w[0], 1'b1);

        // rise coincident with a valid load is discarded
        sec = 1'b0;
        @(negedge clk);
        sec = 1'b1;
        do_load(2'd0, 4'd8, 3'd0, 4'd0, 1'b0);
        chk_time("load_rise", 0, {2'd0, 4'd8, 3'd0, 4'd0, 3'd0, 4'd0});
        chk_bit("load_rise_notick", tick_w[0], 1'b0);
        idle(2);

        // hour adjust across 11 -> 12 (pm toggle), held minute adjust wraps
        inc_hr = 1'b1;
        idle(4);
        inc_hr = 1'b0;
        chk_time("inc_hr12", 1, {2'd1, 4'd2, 3'd0, 4'd0, 3'd0, 4'd0});
        chk_bit("inc_hr_pm", pm_w[1], 1'b1);
        inc_min = 1'b1;
        idle(61);
        inc_min = 1'b0; inc_hr = 1'b0;
        inc_min = 1'b1; inc_hr = 1'b1;
        idle(1);
        inc_min = 1'b0; inc_hr = 1'b0;
        inc_hr = 1'b1;
        idle(14);
        inc_hr = 1'b0;

        // pending tick cleared by a load
        sec = 1'b0;
        @(negedge clk);
        sec = 1'b1; inc_min = 1'b1;
        @(negedge clk);
        inc_min = 1'b0;
        do_load(2'd0, 4'd9, 3'd4, 4'd5, 1'b1);
        idle(3);
        rises(3);

        // reset while a tick is pending
        sec = 1'b0;
        @(negedge clk);
        sec = 1'b1; inc_hr = 1'b1;
        @(negedge clk);
        inc_hr = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(10);
        chk_time("rst_pend", 0, {2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd0});
        chk_bit("rst_pend_notick", tick_w[0], 1'b0);
        rises(2);
        idle(2);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
